shift_unit_pipe: RTL and testbench

- Parametrised, pipelined barrel shifter. Successor to the single-cycle 32-bit left shifter in the ALU datapath.
- Supports five ops: SLL, SRL, SRA, ROL, ROR.
- Register stage count is selectable; valid/ready handshake on both sides.
- Sidecar tag carried alongside each operation.
- Sits between the execute-stage operand muxes and the writeback mux. Flush input squashes in-flight ops on branch mispredict.

---
 rtl/shift_unit_pipe.sv | 138 +++++++++++++
 tb/tb_shift_unit_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready handshake,
// flush, and a sideband tag. The shift levels are spread over STAGES register groups.
module shift_unit_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 5,
   localparam int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic [SHW-1:0]   shamt_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic [TAG_W-1:0] tag_o,
   output logic             err_o
);

   typedef enum logic [2:0] {
      OP_SLL = 3'd0,
      OP_SRL = 3'd1,
      OP_SRA = 3'd2,
      OP_ROL = 3'd3,
      OP_ROR = 3'd4
   } op_e;

   // One level shifts by 2^lvl; SRA fills with the sign captured at accept.
   function automatic logic [WIDTH-1:0] shift_level(
      input logic [WIDTH-1:0] d,
      input op_e              op,
      input logic             sign,
      input int unsigned      lvl
   );
      int unsigned      amt;
      logic [WIDTH-1:0] ones;
      amt  = 32'd1 << lvl;
      ones = '1;
      case (op)
         OP_SLL:  shift_level = d << amt;
         OP_SRL:  shift_level = d >> amt;
         OP_SRA:  shift_level = sign ? ((d >> amt) | ~(ones >> amt)) : (d >> amt);
         OP_ROL:  shift_level = (d << amt) | (d >> (WIDTH - amt));
         OP_ROR:  shift_level = (d >> amt) | (d << (WIDTH - amt));
         default: shift_level = d;
      endcase
   endfunction

   logic en;
   logic accept;

   assign en      = ready_i || !valid_o;
   assign ready_o = en && !flush_i;
   assign accept  = valid_i && ready_o;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int unsigned LO = (s * SHW) / STAGES;
      localparam int unsigned HI = ((s + 1) * SHW) / STAGES;

      logic [WIDTH-1:0] src_data;
      logic [SHW-1:0]   src_shamt;
      op_e              src_op;
      logic             src_sign;
      logic             src_err;
      logic             src_valid;
      logic [TAG_W-1:0] src_tag;
      logic [WIDTH-1:0] lvl [LO:HI];

      logic [WIDTH-1:0] q_data;
      logic [SHW-1:0]   q_shamt;
      op_e              q_op;
      logic             q_sign;
      logic             q_err;
      logic             q_valid;
      logic [TAG_W-1:0] q_tag;

      if (s == 0) begin : g_head
         assign src_data  = data_i;
         assign src_shamt = shamt_i;
         assign src_op    = op_e'(op_i);
         assign src_sign  = data_i[WIDTH-1];
         assign src_err   = (op_i > 3'd4);
         assign src_valid = accept;
         assign src_tag   = tag_i;
      end else begin : g_body
         assign src_data  = g_stage[s-1].q_data;
         assign src_shamt = g_stage[s-1].q_shamt;
         assign src_op    = g_stage[s-1].q_op;
         assign src_sign  = g_stage[s-1].q_sign;
         assign src_err   = g_stage[s-1].q_err;
         assign src_valid = g_stage[s-1].q_valid;
         assign src_tag   = g_stage[s-1].q_tag;
      end

      assign lvl[LO] = src_data;
      for (genvar l = LO; l < HI; l++) begin : g_lvl
         assign lvl[l+1] = src_shamt[l] ? shift_level(lvl[l], src_op, src_sign, l) : lvl[l];
      end

      // Flush clears valid regardless of stall; payload only moves on en.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_shamt <= '0;
            q_op    <= OP_SLL;
            q_sign  <= 1'b0;
            q_err   <= 1'b0;
            q_tag   <= '0;
         end else begin
            if (flush_i)  q_valid <= 1'b0;
            else if (en)  q_valid <= src_valid;
            if (en) begin
               q_data  <= lvl[HI];
               q_shamt <= src_shamt;
               q_op    <= src_op;
               q_sign  <= src_sign;
               q_err   <= src_err;
               q_tag   <= src_tag;
            end
         end
      end
   end

   assign valid_o = g_stage[STAGES-1].q_valid;
   assign data_o  = g_stage[STAGES-1].q_data;
   assign tag_o   = g_stage[STAGES-1].q_tag;
   assign err_o   = g_stage[STAGES-1].q_err;

   a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_o && !ready_i) |=> $stable({data_o, tag_o, err_o}));

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe: STAGES=2 main instance plus STAGES=1/5
// instances sharing the same inputs for latency checks.
module tb_shift_unit_pipe;
   localparam int unsigned W  = 32;
   localparam int unsigned TW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          valid;
   logic          res_ready;
   logic [2:0]    op;
   logic [W-1:0]  data;
   logic [4:0]    shamt;
   logic [TW-1:0] tag;

   logic rdy2, val2, err2, rdy1, val1, err1, rdy5, val5, err5;
   logic [W-1:0]  dat2, dat1, dat5;
   logic [TW-1:0] tag2, tag1, tag5;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shift_unit_pipe #(.WIDTH(W), .STAGES(2), .TAG_W(TW)) u_s2 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(rdy2),
      .op_i(op), .data_i(data), .shamt_i(shamt), .tag_i(tag), .valid_o(val2),
      .ready_i(res_ready), .data_o(dat2), .tag_o(tag2), .err_o(err2));

   shift_unit_pipe #(.WIDTH(W), .STAGES(1), .TAG_W(TW)) u_s1 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(rdy1),
      .op_i(op), .data_i(data), .shamt_i(shamt), .tag_i(tag), .valid_o(val1),
      .ready_i(res_ready), .data_o(dat1), .tag_o(tag1), .err_o(err1));

   shift_unit_pipe #(.WIDTH(W), .STAGES(5), .TAG_W(TW)) u_s5 (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(rdy5),
      .op_i(op), .data_i(data), .shamt_i(shamt), .tag_i(tag), .valid_o(val5),
      .ready_i(res_ready), .data_o(dat5), .tag_o(tag5), .err_o(err5));

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] o, input logic [W-1:0] d, input logic [4:0] sh,
                        input logic [TW-1:0] t);
      valid = 1'b1;
      op    = o;
      data  = d;
      shamt = sh;
      tag   = t;
   endtask

   task automatic run_one(input string name, input logic [2:0] o, input logic [W-1:0] d,
                          input logic [4:0] sh, input logic [W-1:0] exp, input logic exp_err,
                          input logic [TW-1:0] t);
      drive(o, d, sh, t);
      step();
      valid = 1'b0;
      check({name, "_early"}, val2, 0);
      step();
      check({name, "_valid"}, val2, 1);
      check({name, "_data"}, dat2, exp);
      check({name, "_tag"}, tag2, t);
      check({name, "_err"}, err2, exp_err);
   endtask

   task automatic run_stream(input bit stall);
      int sent = 0;
      int recv = 0;
      for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
         if (sent < 8) drive(3'b000, 32'h1, 5'(sent * 4), TW'(sent));
         else valid = 1'b0;
         res_ready = !(stall && cyc >= 4 && cyc <= 6);
         #1;
         if (!res_ready && val2) check("stall_ready", rdy2, 0);
         if (!stall && recv > 0) check("stream_gap", val2, 1);
         if (val2) begin
            check("stream_data", dat2, 32'h1 << (4 * recv));
            check("stream_tag", tag2, recv);
            if (res_ready) recv++;
         end
         if (valid && rdy2) sent++;
         step();
      end
      valid     = 1'b0;
      res_ready = 1'b1;
      check("stream_count", recv, 8);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; valid = 1'b0; res_ready = 1'b1;
      op = '0; data = '0; shamt = '0; tag = '0;
      step();
      step();
      rst_n = 1'b1;
      #1;
      check("rst_valid", val2, 0);
      check("rst_data", dat2, 0);
      check("rst_tag", tag2, 0);
      check("rst_err", err2, 0);
      check("rst_ready", rdy2, 1);
      step();

      // Latency equals STAGES for 1, 2 and 5.
      drive(3'b000, 32'h0000_0001, 5'd31, 5'd3);
      step();
      valid = 1'b0;
      check("lat1_valid", val1, 1);
      check("lat1_data", dat1, 32'h8000_0000);
      check("lat2_early", val2, 0);
      check("lat5_early", val5, 0);
      step();
      check("lat2_valid", val2, 1);
      check("lat2_data", dat2, 32'h8000_0000);
      check("lat2_tag", tag2, 3);
      check("lat1_gone", val1, 0);
      step();
      step();
      check("lat5_early2", val5, 0);
      step();
      check("lat5_valid", val5, 1);
      check("lat5_data", dat5, 32'h8000_0000);
      step();

      run_one("srl4",  3'b001, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 5'd1);
      run_one("sra4",  3'b010, 32'h8000_0010, 5'd4,  32'hF800_0001, 1'b0, 5'd2);
      run_one("sra28", 3'b010, 32'h7000_0000, 5'd28, 32'h0000_0007, 1'b0, 5'd3);
      run_one("ror4",  3'b100, 32'h0000_00F1, 5'd4,  32'h1000_000F, 1'b0, 5'd4);
      run_one("rol1",  3'b011, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, 5'd5);
      run_one("rsv",   3'b110, 32'h1234_5678, 5'd5,  32'h1234_5678, 1'b1, 5'd7);
      run_one("sra0",  3'b010, 32'h8000_00A5, 5'd0,  32'h8000_00A5, 1'b0, 5'd8);
      step();

      run_stream(1'b0);
      step();
      step();
      run_stream(1'b1);
      step();
      step();

      // Flush while stalled with two ops in flight.
      res_ready = 1'b0;
      drive(3'b001, 32'h8000_0000, 5'd4, 5'd1);
      step();
      drive(3'b000, 32'h0000_0001, 5'd1, 5'd2);
      step();
      check("fl_head_valid", val2, 1);
      check("fl_head_data", dat2, 32'h0800_0000);
      drive(3'b000, 32'h0000_0001, 5'd2, 5'd3);
      flush = 1'b1;
      #1;
      check("fl_ready", rdy2, 0);
      step();
      flush = 1'b0;
      check("fl_cleared", val2, 0);
      res_ready = 1'b1;
      drive(3'b100, 32'h0000_00F1, 5'd4, 5'd9);
      step();
      valid = 1'b0;
      check("fl_no_ghost", val2, 0);
      step();
      check("fl_next_valid", val2, 1);
      check("fl_next_data", dat2, 32'h1000_000F);
      check("fl_next_tag", tag2, 9);
      step();

      // Asynchronous reset while a result is presented.
      drive(3'b000, 32'h0000_0001, 5'd31, 5'd4);
      step();
      valid = 1'b0;
      step();
      check("mr_pre_valid", val2, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_async_valid", val2, 0);
      #2 rst_n = 1'b1;
      #1;
      check("mr_ready", rdy2, 1);
      check("mr_data", dat2, 0);
      check("mr_tag", tag2, 0);
      check("mr_err", err2, 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
